// File: rtl/counter_pkg.sv
// Shared helpers for the modulo-M counter family (up and down counters).
// Holds the terminal-value function and the WIDTH/MODULUS legality check.
package counter_pkg;

    function automatic int unsigned terminal_value(input int unsigned modulus);
        return modulus - 1;
    endfunction

    // Widened to longint so that 2^WIDTH does not overflow for wide counters.
    function automatic bit params_legal(input int width, input longint modulus);
        if (width < 1 || width > 62) return 1'b0;
        return (modulus >= 2) && (modulus <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/up_counter_mod_dff.sv
// 1-bit D flip-flop with asynchronous active-high reset to 0.
// Every state bit of the counter is one of these cells.
module dff_rst_h (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end

endmodule

// File: rtl/up_counter_mod.sv
// Synchronous modulo-M up counter with clear, parallel load and enable.
// State lives in per-bit dff_rst_h cells; next-state logic is a priority mux.
module up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             carry,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
            $fatal(1, "up_counter_mod: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
        end
    endgenerate

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(terminal_value(MODULUS));
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             err_next;
    logic             din_legal;

    assign tc        = (Q == TERM);
    assign carry     = tc & en & ~clr & ~load;
    assign din_legal = ({1'b0, din} < MOD_EXT);

    // Priority: clr > load > en > hold. The tc compare wins over the increment,
    // so Q + 1 never needs to roll over WIDTH.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        q_next    = Q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            if (din_legal) q_next = din;
            else           err_next = 1'b1;
        end else if (en) begin
            if (tc) begin
                q_next    = '0;
                wrap_next = 1'b1;
            end else begin
                q_next = Q + WIDTH'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_q_bits
            dff_rst_h u_q (.clk(clk), .reset(reset), .d(q_next[i]), .q(Q[i]));
        end
    endgenerate

    dff_rst_h u_wrap (.clk(clk), .reset(reset), .d(wrap_next), .q(wrap));
    dff_rst_h u_err  (.clk(clk), .reset(reset), .d(err_next),  .q(load_err));

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: MODULUS=6 vector table, MODULUS=8 run,
// two-stage base-3 cascade and asynchronous reset in mid-count.
module tb_up_counter_mod;

    typedef struct {
        logic       en;
        logic       clr;
        logic       load;
        logic [2:0] din;
        logic       exp_carry;
        logic [2:0] exp_q;
        logic       exp_tc;
        logic       exp_wrap;
        logic       exp_err;
    } vec_t;

    int n_checked = 0;
    int n_failed  = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // MODULUS=6 device
    logic       en6, clr6, load6;
    logic [2:0] din6, q6;
    logic       tc6, carry6, wrap6, err6;

    // MODULUS=8 device
    logic       en8;
    logic       clr8  = 1'b0;
    logic       load8 = 1'b0;
    logic [2:0] din8  = 3'd0;
    logic [2:0] q8;
    logic       tc8, carry8, wrap8, err8;

    // Cascade of two WIDTH=2, MODULUS=3 stages
    logic       c_en;
    logic       c_zero = 1'b0;
    logic [1:0] c_din  = 2'd0;
    logic [1:0] lo_q, hi_q;
    logic       lo_tc, lo_carry, lo_wrap, lo_err;
    logic       hi_tc, hi_carry, hi_wrap, hi_err;

    up_counter_mod #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk(clk), .reset(reset), .en(en6), .clr(clr6), .load(load6), .din(din6),
        .Q(q6), .tc(tc6), .carry(carry6), .wrap(wrap6), .load_err(err6));

    up_counter_mod #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .clr(clr8), .load(load8), .din(din8),
        .Q(q8), .tc(tc8), .carry(carry8), .wrap(wrap8), .load_err(err8));

    up_counter_mod #(.WIDTH(2), .MODULUS(3)) dut_lo (
        .clk(clk), .reset(reset), .en(c_en), .clr(c_zero), .load(c_zero), .din(c_din),
        .Q(lo_q), .tc(lo_tc), .carry(lo_carry), .wrap(lo_wrap), .load_err(lo_err));

    up_counter_mod #(.WIDTH(2), .MODULUS(3)) dut_hi (
        .clk(clk), .reset(reset), .en(lo_carry), .clr(c_zero), .load(c_zero), .din(c_din),
        .Q(hi_q), .tc(hi_tc), .carry(hi_carry), .wrap(hi_wrap), .load_err(hi_err));

    task automatic check(input string name, input int act, input int exp);
        n_checked++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        en6 = 0; clr6 = 0; load6 = 0; din6 = 0;
        en8 = 0; c_en = 0;

        // en clr load din | carry(pre-edge) | q tc wrap err (post-edge)
        vecs.push_back('{1,0,0,3'd0, 0, 3'd1,0,0,0});
        vecs.push_back('{1,0,0,3'd0, 0, 3'd2,0,0,0});
        vecs.push_back('{1,0,0,3'd0, 0, 3'd3,0,0,0});
        vecs.push_back('{1,0,0,3'd0, 0, 3'd4,0,0,0});
        vecs.push_back('{1,0,0,3'd0, 0, 3'd5,1,0,0});
        vecs.push_back('{1,0,0,3'd0, 1, 3'd0,0,1,0});  // 5 -> 0 wraps
        vecs.push_back('{1,0,0,3'd0, 0, 3'd1,0,0,0});
        vecs.push_back('{0,0,1,3'd5, 0, 3'd5,1,0,0});  // legal load
        vecs.push_back('{1,0,0,3'd0, 1, 3'd0,0,1,0});
        vecs.push_back('{0,0,1,3'd7, 0, 3'd0,0,0,1});  // rejected load
        vecs.push_back('{0,0,0,3'd0, 0, 3'd0,0,0,0});  // err lasts one cycle
        vecs.push_back('{1,0,1,3'd6, 0, 3'd0,0,0,1});  // din == MODULUS rejected, no count
        vecs.push_back('{0,0,1,3'd3, 0, 3'd3,0,0,0});
        vecs.push_back('{1,0,0,3'd0, 0, 3'd4,0,0,0});
        vecs.push_back('{1,1,1,3'd2, 0, 3'd0,0,0,0});  // clr beats load and en
        vecs.push_back('{0,0,0,3'd0, 0, 3'd0,0,0,0});
        vecs.push_back('{0,0,0,3'd0, 0, 3'd0,0,0,0});
        vecs.push_back('{0,0,0,3'd0, 0, 3'd0,0,0,0});
        vecs.push_back('{0,0,1,3'd5, 0, 3'd5,1,0,0});
        vecs.push_back('{1,0,1,3'd1, 0, 3'd1,0,0,0});  // load beats en at tc
        vecs.push_back('{0,0,1,3'd5, 0, 3'd5,1,0,0});
        vecs.push_back('{1,1,0,3'd0, 0, 3'd0,0,0,0});  // clr at tc: no wrap

        #12;
        check("reset q6", q6, 0);
        check("reset wrap6", wrap6, 0);
        check("reset err6", err6, 0);
        @(negedge clk) reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            en6 = vecs[i].en; clr6 = vecs[i].clr; load6 = vecs[i].load; din6 = vecs[i].din;
            #1;
            check($sformatf("v%0d carry", i), carry6, vecs[i].exp_carry);
            @(posedge clk); #1;
            check($sformatf("v%0d q", i), q6, vecs[i].exp_q);
            check($sformatf("v%0d tc", i), tc6, vecs[i].exp_tc);
            check($sformatf("v%0d wrap", i), wrap6, vecs[i].exp_wrap);
            check($sformatf("v%0d load_err", i), err6, vecs[i].exp_err);
        end
        @(negedge clk);
        en6 = 0; clr6 = 0; load6 = 0;

        // MODULUS=8: reset pulse then 10 counting edges
        reset = 1'b1;
        @(negedge clk);
        check("m8 reset q", q8, 0);
        reset = 1'b0; en8 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("m8 q k=%0d", k), q8, k % 8);
            check($sformatf("m8 tc k=%0d", k), tc8, (k % 8) == 7);
            check($sformatf("m8 carry k=%0d", k), carry8, (k % 8) == 7);
            check($sformatf("m8 wrap k=%0d", k), wrap8, k == 8);
            check($sformatf("m8 err k=%0d", k), err8, 0);
        end
        @(negedge clk) en8 = 1'b0;

        // Cascade: combined hi*3+lo counts 0..8 then wraps
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("casc lo k=%0d", k), lo_q, k % 3);
            check($sformatf("casc hi k=%0d", k), hi_q, (k % 9) / 3);
            check($sformatf("casc lo_tc k=%0d", k), lo_tc, (k % 3) == 2);
            check($sformatf("casc hi_tc k=%0d", k), hi_tc, ((k % 9) / 3) == 2);
            check($sformatf("casc hi_carry k=%0d", k), hi_carry, (k % 9) == 8);
            check($sformatf("casc lo_wrap k=%0d", k), lo_wrap, (k % 3) == 0);
            check($sformatf("casc hi_wrap k=%0d", k), hi_wrap, (k % 9) == 0);
            check($sformatf("casc errs k=%0d", k), lo_err | hi_err, 0);
        end
        @(negedge clk) c_en = 1'b0;

        // Async reset mid-count: Q=5 with load_err high, reset 2 units after the edge
        load6 = 1'b1; din6 = 3'd5;
        @(negedge clk) din6 = 3'd7;
        @(posedge clk); #1;
        check("pre-reset q6", q6, 5);
        check("pre-reset err6", err6, 1);
        load6 = 1'b0; en6 = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("async reset q6", q6, 0);
        check("async reset wrap6", wrap6, 0);
        check("async reset err6", err6, 0);
        @(posedge clk); #1;
        check("held in reset q6", q6, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("first count after release", q6, 1);
        en6 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
        $finish;
    end

endmodule
